// File: rtl/bool_combine_pkg.sv
// Shared encodings, payload control fields and the bitwise operator helper
// for the boolean combine pipeline.
package bool_combine_pkg;

  // Final-operator encodings carried on op_sel.
  localparam logic [1:0] OP_XOR  = 2'd0;
  localparam logic [1:0] OP_XNOR = 2'd1;
  localparam logic [1:0] OP_OR   = 2'd2;
  localparam logic [1:0] OP_AND  = 2'd3;

  // Width-independent control part of the S1 payload. The a/b operand fields
  // depend on WIDTH, so the full payload struct is completed in the top.
  typedef struct packed {
    logic [1:0] op;
    logic       acc_mode;
    logic       last;
  } s1_ctrl_t;

  // Single-bit operator. The top applies it per bit, which keeps the helper
  // usable for any WIDTH.
  function automatic logic apply_op(input logic [1:0] op, input logic a, input logic b);
    logic res;
    case (op)
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// Parametrised valid/ready register slice. Accepts a new word whenever it is
// empty or its current word is leaving in the same cycle.
module pipe_slice #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [Width-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [Width-1:0] o_data
);

  logic             r_valid;
  logic [Width-1:0] r_data;

  assign o_ready = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Slice register: load on upstream transfer, empty when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/bool_combine_pipe.sv
// Two-stage boolean combiner: S1 registers a=x|y and b=x&y, then the final
// operator result is either written to the output slice or folded into an
// XOR accumulator for multi-beat packets.
module bool_combine_pipe
  import bool_combine_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op_sel,
  input  logic             acc_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             out_last,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    s1_ctrl_t         ctrl;
  } s1_payload_t;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } out_payload_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  s1_payload_t  w_s1_in;
  s1_payload_t  w_s1_out;
  logic         w_s1_valid;
  logic         w_s1_ready_dn;
  logic [WIDTH-1:0] w_r;
  logic         w_acc_hold;
  logic         w_out_in_valid;
  logic         w_out_in_ready;
  out_payload_t w_out_in;
  out_payload_t w_out_data;

  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  // S1 payload formed straight from the input beat.
  always_comb begin
    w_s1_in               = '0;
    w_s1_in.a             = x | y;
    w_s1_in.b             = x & y;
    w_s1_in.ctrl.op       = op_sel;
    w_s1_in.ctrl.acc_mode = acc_mode;
    w_s1_in.ctrl.last     = in_last;
  end

  pipe_slice #(
    .Width($bits(s1_payload_t))
  ) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_s1_in),
    .o_valid (w_s1_valid),
    .i_ready (w_s1_ready_dn),
    .o_data  (w_s1_out)
  );

  // Final operator evaluated bit by bit on the S1 operands.
  always_comb begin
    w_r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_r[i] = apply_op(w_s1_out.ctrl.op, w_s1_out.a[i], w_s1_out.b[i]);
    end
  end

  // Routing between S1, the accumulator and the output slice. Non-last
  // accumulate beats only touch the accumulator, so they never wait on the sink.
  always_comb begin
    w_acc_hold     = w_s1_out.ctrl.acc_mode & ~w_s1_out.ctrl.last;
    w_out_in_valid = w_s1_valid & ~w_acc_hold;
    w_s1_ready_dn  = w_acc_hold | w_out_in_ready;
    w_out_in       = '0;
    w_out_in.last  = 1'b1;
    if (w_s1_out.ctrl.acc_mode) begin
      w_out_in.z   = r_acc ^ w_r;
      w_out_in.cnt = sat_inc(r_cnt);
    end else begin
      w_out_in.z   = w_r;
      w_out_in.cnt = CNT_W'(1);
    end
  end

  // Accumulator: fold open-packet beats, clear when the closing beat is output.
  // Per-beat (acc_mode=0) results leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_s1_valid && w_s1_out.ctrl.acc_mode) begin
      if (!w_s1_out.ctrl.last) begin
        r_acc <= r_acc ^ w_r;
        r_cnt <= sat_inc(r_cnt);
      end else if (w_out_in_ready) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end

  pipe_slice #(
    .Width($bits(out_payload_t))
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_out_in_valid),
    .o_ready (w_out_in_ready),
    .i_data  (w_out_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_data)
  );

  assign z        = w_out_data.z;
  assign out_last = w_out_data.last;
  assign beat_cnt = w_out_data.cnt;

endmodule

// File: doc/bool_combine_pipe.md
Name: bool_combine_pipe

Overview:
Parametrised, pipelined successor to the fixed two-input OR/AND/XOR combiner. It accepts WIDTH-bit operand pairs over a valid/ready handshake and forms a = x|y and b = x&y bitwise. It then combines a and b with a selectable final operator. An optional accumulate mode folds a multi-beat packet into one XOR-reduced result. It sits between an operand source and a result sink, and both may stall.

Parameters:
WIDTH, 8, operand/result bit width (>=1)
CNT_W, 8, width of beat counter (>=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept beat this cycle
x  in  WIDTH  operand x
y  in  WIDTH  operand y
op_sel  in  2  final operator: 0 XOR, 1 XNOR, 2 OR, 3 AND (sampled with beat)
acc_mode  in  1  0 per-beat result, 1 accumulate packet (sampled with beat)
in_last  in  1  last beat of packet (ignored when acc_mode=0)
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
z  out  WIDTH  result
out_last  out  1  result closes a packet (1 for every acc_mode=0 result)
beat_cnt  out  CNT_W  beats folded into z, saturating at 2^CNT_W-1

Behaviour:
- Reset (async, immediate): out_valid=0, z=0, out_last=0, beat_cnt=0, accumulator=0, acc count=0, all stage valids=0. in_ready=1 from the first cycle after rst deasserts. A packet in flight is discarded and emits no result.
- Handshake: transfer occurs when valid&ready are both 1 in the same cycle. Once out_valid=1, z, out_last and beat_cnt hold stable until out_ready=1.
- Stage S1 (register): on accept, capture a=x|y, b=x&y, op_sel, acc_mode, in_last.
- Stage S2 (register): r = OP(op_sel, a, b), evaluated bitwise.
  - acc_mode=0: z=r, beat_cnt=1, out_last=1. Accumulator is untouched.
  - acc_mode=1, last=0: acc ^= r and cnt = sat(cnt+1). Nothing is written to the output register. This beat always advances, even while the output register is stalled.
  - acc_mode=1, last=1: z = acc^r, beat_cnt = sat(cnt+1), out_last=1. acc and cnt clear to 0 in the same cycle.
- Stall rule per stage: stage_ready = !stage_valid | next_ready. in_ready = S1 ready. in_ready has no combinational dependency on in_valid.
- Latency: 2 cycles from accepted beat to out_valid (beat in cycle N, out_valid in N+2). Sustained throughput is 1 beat per cycle when out_ready=1.
- Full stall: with out_ready=0 held, at most 2 beats are buffered (S1 plus output register). in_ready drops to 0 in the cycle after the second beat is accepted. No beat is lost or duplicated.
- Counter: saturates at 2^CNT_W-1 and does not wrap. Example with CNT_W=2: a 5-beat packet reports 3.
- Mixed modes: an acc_mode=0 beat arriving inside an open accumulate packet is output normally. The open packet's acc and cnt are preserved and resume with the next acc_mode=1 beat.
- Single-beat packet (acc_mode=1, in_last=1 on the first beat): z=r, beat_cnt=1.

Decomposition:
- Package bool_combine_pkg holds:
  - op_sel encodings (OP_XOR=0, OP_XNOR=1, OP_OR=2, OP_AND=3);
  - a function apply_op(op, a, b);
  - the S1 payload struct {a, b, op, acc_mode, last}.
- One sub-module, pipe_slice: a parametrised valid/ready register slice (payload width param, async active-high reset). It is used for S1 and for the output register. The accumulator logic stays in the top module.

Test Plan:
- WIDTH=8, acc_mode=0, op XOR, x=0xF0, y=0x3C, out_ready=1 -> a=0xFC, b=0x30. z=0xCC two cycles after accept, beat_cnt=1, out_last=1.
- Same x/y, ops XNOR/OR/AND back-to-back -> z=0x33, 0xFC, 0x30 on consecutive cycles, in order, throughput 1/cycle.
- acc_mode=1, op XOR, 3 beats (x,y) = (0x01,0x00), (0x02,0x00), (0x04,0x00), last on beat 3 -> exactly one result: z=0x07, beat_cnt=3, out_last=1. The accumulator then reads 0.
- out_ready=0 while 4 acc_mode=0 beats are offered -> 2 accepted, in_ready=0 thereafter. On releasing out_ready, all 4 results appear in order with none dropped.
- CNT_W=2, 5-beat accumulate packet -> beat_cnt=3 (saturated) and z equal to the XOR of all 5 r values.
- Assert rst mid-packet after 2 accumulate beats -> outputs go to 0 immediately. A following 1-beat packet with x=0xAA, y=0x00 gives z=0xAA, beat_cnt=1.
